// File: rtl/rx_burst_checker_if.sv
// Demodulator-to-checker bus: I/Q samples and slicer symbols in, carrier/lock state and
// per-burst results out.
interface rx_burst_checker_if #(
    parameter int unsigned IQ_BITS = 6
);
    logic                      sample_strobe;
    logic signed [IQ_BITS-1:0] rx_inphase;
    logic signed [IQ_BITS-1:0] rx_quadrature;
    logic                      symbol_strobe;
    logic                      rx_symbol;
    logic                      carrier_detect;
    logic                      locked;
    logic                      burst_done;
    logic                      sync_fail;
    logic [7:0]                burst_bits;
    logic [7:0]                burst_errors;

    modport master (
        output sample_strobe, rx_inphase, rx_quadrature, symbol_strobe, rx_symbol,
        input  carrier_detect, locked, burst_done, sync_fail, burst_bits, burst_errors
    );

    modport slave (
        input  sample_strobe, rx_inphase, rx_quadrature, symbol_strobe, rx_symbol,
        output carrier_detect, locked, burst_done, sync_fail, burst_bits, burst_errors
    );
endinterface

// File: rtl/rx_burst_checker.sv
// Burst receiver checker: energy-based carrier detect, self-synchronising PRBS predictor,
// per-burst symbol and bit-error counts.
module rx_burst_checker #(
    parameter int unsigned IQ_BITS      = 6,
    parameter int unsigned AVG_SHIFT    = 4,
    parameter int unsigned ON_THRESH    = 12,
    parameter int unsigned OFF_THRESH   = 6,
    parameter int unsigned SYNC_LEN     = 16,
    parameter int unsigned SYNC_TIMEOUT = 96,
    parameter int unsigned MAX_SYMBOLS  = 64,
    parameter logic [5:0]  PRBS_TAPS    = 6'h2d
) (
    input logic             clock,
    input logic             reset_n,
    rx_burst_checker_if.slave bus
);
    localparam int unsigned MAG_BITS = IQ_BITS + 1;
    localparam int unsigned ACC_BITS = MAG_BITS + AVG_SHIFT;
    localparam int unsigned HIST_LEN = 6;
    localparam int unsigned FILL_W   = $clog2(HIST_LEN + 1);
    localparam int unsigned RUN_W    = $clog2(SYNC_LEN + 1);
    localparam int unsigned SCNT_W   = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [IQ_BITS:0]  w_i_ext, w_q_ext, w_abs_i, w_abs_q;
    logic [MAG_BITS-1:0] w_mag, w_avg;
    logic [ACC_BITS-1:0] w_acc_d;
    logic                w_cd_rise, w_pred;

    logic [MAG_BITS-1:0] r_mag;
    logic                r_mag_vld;
    logic [ACC_BITS-1:0] r_acc;
    logic                r_cd, r_cd_prev;

    logic [1:0]          r_state, w_state_d;
    logic [HIST_LEN-1:0] r_hist, w_hist_d;
    logic [FILL_W-1:0]   r_fill, w_fill_d;
    logic [RUN_W-1:0]    r_run, w_run_d;
    logic [SCNT_W-1:0]   r_scnt, w_scnt_d;
    logic [7:0]          r_bits, w_bits_d, r_errs, w_errs_d;
    logic [7:0]          r_bbits, w_bbits_d, r_berrs, w_berrs_d;
    logic                r_locked, w_locked_d, r_done, w_done_d, r_fail, w_fail_d;

    // Sign-extend by one bit so |-2^(N-1)| is representable.
    assign w_i_ext = {bus.rx_inphase[IQ_BITS-1], bus.rx_inphase};
    assign w_q_ext = {bus.rx_quadrature[IQ_BITS-1], bus.rx_quadrature};
    assign w_abs_i = w_i_ext[IQ_BITS] ? (~w_i_ext + 1'b1) : w_i_ext;
    assign w_abs_q = w_q_ext[IQ_BITS] ? (~w_q_ext + 1'b1) : w_q_ext;
    assign w_mag   = w_abs_i + w_abs_q;

    assign w_acc_d   = r_acc + ACC_BITS'(r_mag) - (r_acc >> AVG_SHIFT);
    assign w_avg     = r_acc[ACC_BITS-1:AVG_SHIFT];
    assign w_cd_rise = r_cd & ~r_cd_prev;
    assign w_pred    = ^(r_hist & PRBS_TAPS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mag     <= '0;
            r_mag_vld <= 1'b0;
            r_acc     <= '0;
            r_cd      <= 1'b0;
            r_cd_prev <= 1'b0;
        end else begin
            r_mag_vld <= bus.sample_strobe;
            if (bus.sample_strobe) r_mag <= w_mag;
            if (r_mag_vld) r_acc <= w_acc_d;
            if (w_avg >= MAG_BITS'(ON_THRESH)) r_cd <= 1'b1;
            else if (w_avg < MAG_BITS'(OFF_THRESH)) r_cd <= 1'b0;
            r_cd_prev <= r_cd;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_hist_d   = r_hist;
        w_fill_d   = r_fill;
        w_run_d    = r_run;
        w_scnt_d   = r_scnt;
        w_bits_d   = r_bits;
        w_errs_d   = r_errs;
        w_bbits_d  = r_bbits;
        w_berrs_d  = r_berrs;
        w_locked_d = r_locked;
        w_done_d   = 1'b0;
        w_fail_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Rising edge only: a burst tail still above threshold cannot re-trigger.
                if (w_cd_rise) begin
                    w_state_d = ST_SYNC;
                    w_fill_d  = '0;
                    w_run_d   = '0;
                    w_scnt_d  = '0;
                end
            end
            ST_SYNC: begin
                if (!r_cd) begin
                    w_state_d = ST_IDLE;
                    w_fail_d  = 1'b1;
                end else if (bus.symbol_strobe) begin
                    w_hist_d = {r_hist[HIST_LEN-2:0], bus.rx_symbol};
                    w_scnt_d = r_scnt + 1'b1;
                    if (r_fill != FILL_W'(HIST_LEN)) w_fill_d = r_fill + 1'b1;
                    else if (bus.rx_symbol == w_pred) w_run_d = r_run + 1'b1;
                    else w_run_d = '0;
                    if (w_run_d == RUN_W'(SYNC_LEN)) begin
                        w_state_d  = ST_TRACK;
                        w_locked_d = 1'b1;
                        w_bits_d   = '0;
                        w_errs_d   = '0;
                    end else if (w_scnt_d == SCNT_W'(SYNC_TIMEOUT)) begin
                        w_state_d = ST_IDLE;
                        w_fail_d  = 1'b1;
                    end
                end
            end
            ST_TRACK: begin
                if (bus.symbol_strobe) begin
                    // Flywheel on the prediction so one channel error costs one count.
                    w_hist_d = {r_hist[HIST_LEN-2:0], w_pred};
                    if (r_bits != 8'hff) w_bits_d = r_bits + 1'b1;
                    if (bus.rx_symbol != w_pred && r_errs != 8'hff) w_errs_d = r_errs + 1'b1;
                end
                if (!r_cd || w_bits_d >= 8'(MAX_SYMBOLS)) w_state_d = ST_DONE;
            end
            default: begin
                w_bbits_d  = r_bits;
                w_berrs_d  = r_errs;
                w_done_d   = 1'b1;
                w_locked_d = 1'b0;
                w_state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_hist   <= '0;
            r_fill   <= '0;
            r_run    <= '0;
            r_scnt   <= '0;
            r_bits   <= '0;
            r_errs   <= '0;
            r_bbits  <= '0;
            r_berrs  <= '0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_hist   <= w_hist_d;
            r_fill   <= w_fill_d;
            r_run    <= w_run_d;
            r_scnt   <= w_scnt_d;
            r_bits   <= w_bits_d;
            r_errs   <= w_errs_d;
            r_bbits  <= w_bbits_d;
            r_berrs  <= w_berrs_d;
            r_locked <= w_locked_d;
            r_done   <= w_done_d;
            r_fail   <= w_fail_d;
        end
    end

    assign bus.carrier_detect = r_cd;
    assign bus.locked         = r_locked;
    assign bus.burst_done     = r_done;
    assign bus.sync_fail      = r_fail;
    assign bus.burst_bits     = r_bbits;
    assign bus.burst_errors   = r_berrs;
endmodule

// File: tb/tb_rx_burst_checker.sv
// Directed bench for rx_burst_checker: energy-detector vector table plus burst sequences.
module tb_rx_burst_checker;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rx_burst_checker_if #(.IQ_BITS(6)) bus ();

    rx_burst_checker dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int i;
        int q;
        int hold;
        bit exp_cd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int n_done = 0, n_fail = 0, n_lock_cyc = 0, n_cd_cyc = 0;
    int last_bits = 0, last_errs = 0, fail_at = 0;
    logic [5:0] g;

    always @(negedge clock) begin
        if (bus.burst_done) begin
            n_done++;
            last_bits = int'(bus.burst_bits);
            last_errs = int'(bus.burst_errors);
        end
        if (bus.sync_fail) begin
            n_fail++;
            fail_at = sent;
        end
        if (bus.locked) n_lock_cyc++;
        if (bus.carrier_detect) n_cd_cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_iq(input int i, input int q);
        bus.rx_inphase    = 6'(i);
        bus.rx_quadrature = 6'(q);
    endtask

    task automatic send_sym(input bit s);
        bus.symbol_strobe = 1'b1;
        bus.rx_symbol     = s;
        sent++;
        tick(1);
        bus.symbol_strobe = 1'b0;
        tick(4);
    endtask

    task automatic wait_cd(input bit v, input int lim, input string name);
        int k = 0;
        while (bus.carrier_detect !== v && k < lim) begin
            tick(1);
            k++;
        end
        check(name, int'(bus.carrier_detect), int'(v));
    endtask

    task automatic wait_done(input int lim, input int d0, input string name);
        int k = 0;
        while (n_done == d0 && k < lim) begin
            tick(1);
            k++;
        end
        check(name, n_done - d0, 1);
    endtask

    task automatic prbs(output bit b);
        b = g[0] ^ g[2] ^ g[3] ^ g[5];
        g = {g[4:0], b};
    endtask

    // Carrier up, then nsyms TX-PRBS symbols; symbols numbered fa/fb/fc are inverted.
    task automatic run_burst(input int nsyms, input int fa, input int fb, input int fc,
                             input bit chk_lock);
        bit b;
        set_iq(20, 20);
        wait_cd(1'b1, 300, "cd_rise");
        tick(3);
        for (int k = 1; k <= nsyms; k++) begin
            prbs(b);
            if (k == fa || k == fb || k == fc) b = ~b;
            send_sym(b);
            if (chk_lock && k == 21) check("not_locked_21", int'(bus.locked), 0);
            if (chk_lock && k == 22) check("locked_22", int'(bus.locked), 1);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cd"},   int'(bus.carrier_detect), 0);
        check({name, "_lock"}, int'(bus.locked), 0);
        check({name, "_done"}, int'(bus.burst_done), 0);
        check({name, "_fail"}, int'(bus.sync_fail), 0);
        check({name, "_bits"}, int'(bus.burst_bits), 0);
        check({name, "_errs"}, int'(bus.burst_errors), 0);
    endtask

    initial begin
        vec_t vecs[10];
        int d0, f0, l0, c0;

        vecs[0] = '{20, 20, 200, 1'b1};   // avg 40
        vecs[1] = '{-5, 4, 200, 1'b1};    // avg 9: hysteresis holds high
        vecs[2] = '{1, -2, 200, 1'b0};    // avg 3
        vecs[3] = '{4, 5, 200, 1'b0};     // avg 9: holds low
        vecs[4] = '{-32, -32, 200, 1'b1}; // avg 64, |-32| = 32
        vecs[5] = '{0, 6, 200, 1'b1};     // avg 6: not below off level
        vecs[6] = '{0, -5, 200, 1'b0};    // avg 5
        vecs[7] = '{7, -5, 200, 1'b1};    // avg 12: on level reached
        vecs[8] = '{-11, 0, 200, 1'b1};   // avg 11
        vecs[9] = '{0, 0, 200, 1'b0};

        g = 6'b000001;
        bus.sample_strobe = 1'b0;
        bus.symbol_strobe = 1'b0;
        bus.rx_symbol     = 1'b0;
        set_iq(0, 0);
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        bus.sample_strobe = 1'b1;
        tick(5);
        check_all_zero("post_reset");

        for (int n = 0; n < 10; n++) begin
            set_iq(vecs[n].i, vecs[n].q);
            tick(vecs[n].hold);
            check($sformatf("energy[%0d]", n), int'(bus.carrier_detect), int'(vecs[n].exp_cd));
            check($sformatf("energy_lock[%0d]", n), int'(bus.locked), 0);
        end

        // Noise only
        d0 = n_done; f0 = n_fail; c0 = n_cd_cyc;
        for (int n = 0; n < 10000; n++) begin
            bus.rx_inphase    = 6'(int'($urandom_range(4)) - 2);
            bus.rx_quadrature = 6'(int'($urandom_range(4)) - 2);
            tick(1);
        end
        set_iq(0, 0);
        tick(5);
        check("noise_cd", n_cd_cyc - c0, 0);
        check("noise_done", n_done - d0, 0);
        check("noise_fail", n_fail - f0, 0);

        // Clean burst
        d0 = n_done;
        run_burst(64, 0, 0, 0, 1'b1);
        set_iq(0, 0);
        wait_done(400, d0, "clean_done");
        check("clean_bits", last_bits, 42);
        check("clean_errs", last_errs, 0);
        check("clean_unlock", int'(bus.locked), 0);
        wait_cd(1'b0, 400, "clean_cd_fall");

        // Three injected errors in TRACK
        d0 = n_done;
        run_burst(64, 30, 40, 50, 1'b0);
        set_iq(0, 0);
        wait_done(400, d0, "err_done");
        check("err_bits", last_bits, 42);
        check("err_errs", last_errs, 3);
        wait_cd(1'b0, 400, "err_cd_fall");

        // Non-PRBS symbols: never lock, fail after the timeout
        d0 = n_done; f0 = n_fail; l0 = n_lock_cyc;
        sent = 0;
        set_iq(-20, 20);
        wait_cd(1'b1, 300, "rand_cd_rise");
        tick(3);
        for (int k = 0; k < 100; k++) send_sym(1'b1);
        check("rand_fail_cnt", n_fail - f0, 1);
        check("rand_fail_at", fail_at, 96);
        check("rand_no_lock", n_lock_cyc - l0, 0);
        check("rand_no_done", n_done - d0, 0);
        set_iq(0, 0);
        wait_cd(1'b0, 400, "rand_cd_fall");
        check("rand_no_fail_on_drop", n_fail - f0, 1);

        // Carrier drop after 20 checked symbols
        d0 = n_done;
        run_burst(42, 0, 0, 0, 1'b0);
        check("drop_locked", int'(bus.locked), 1);
        set_iq(0, 0);
        wait_done(400, d0, "drop_done");
        check("drop_bits", last_bits, 20);
        check("drop_errs", last_errs, 0);
        wait_cd(1'b0, 400, "drop_cd_fall");

        // Reset mid-TRACK, then a normal burst
        run_burst(32, 0, 0, 0, 1'b0);
        check("mid_locked", int'(bus.locked), 1);
        d0 = n_done; f0 = n_fail;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick(3);
        reset_n = 1'b1;
        check("mid_no_done", n_done - d0, 0);
        check("mid_no_fail", n_fail - f0, 0);
        tick(2);
        run_burst(64, 0, 0, 0, 1'b0);
        set_iq(0, 0);
        wait_done(400, d0, "after_reset_done");
        check("after_reset_bits", last_bits, 42);
        check("after_reset_errs", last_errs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
